// File: rtl/decimator_acc.sv
// decimator_acc
// -------------
// Integrate-and-dump decimator. It sums N = 2^Reff unsigned input samples
// into one frame result and presents the full sum and the truncated average
// (sum >> Reff). Reff is min(cfg_log2r, MAX_LOG2R) and is latched on the
// first sample of each frame.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset; it overrides every other input
//   cfg_log2r  : requested log2 decimation ratio; values above MAX_LOG2R clamp
//   sync       : discards the partial frame; a sample given with it is sample 1
//   in_valid   : qualifies in_data; the input has no backpressure
//   in_data    : unsigned input sample
//   out_valid  : out_data/out_sum hold a result that has not been consumed
//   out_ready  : consumer accepts the result
//   out_data   : truncated frame average
//   out_sum    : full frame sum
//   overrun    : sticky; an unconsumed result was overwritten
//   ovr_clr    : clears overrun; a simultaneous overwrite wins
//
// Output handshake: the result transfers on any rising edge where
// out_valid && out_ready. out_valid then drops unless a new result loads in
// the same cycle. A new result always loads, even if the old one is still
// pending. Overwriting a pending result without a handshake sets overrun.
module decimator_acc #(
  parameter int DATA_W    = 12,
  parameter int MAX_LOG2R = 9,
  localparam int ACC_W    = DATA_W + MAX_LOG2R
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cfg_log2r,
  input  logic              sync,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ACC_W-1:0]  out_sum,
  output logic              overrun,
  input  logic              ovr_clr
);

  // The counter holds 0..N-1. One extra bit lets the frame length itself
  // (up to 2^MAX_LOG2R) be represented when it is compared.
  localparam int CNT_W = MAX_LOG2R + 1;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        reff_q, reff_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic              overrun_q, overrun_d;

  logic [3:0]        cfg_clamped;
  logic              frame_start;
  logic [3:0]        reff_cur;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  sum;
  logic              frame_done;

  assign cfg_clamped = (cfg_log2r > 4'(MAX_LOG2R)) ? 4'(MAX_LOG2R) : cfg_log2r;

  // A sample starts a frame when nothing has been accumulated yet, or when
  // sync discards the partial frame in the same cycle. The ratio that sample
  // latches applies to its own frame immediately.
  assign frame_start = (cnt_q == '0) || sync;
  assign reff_cur    = (in_valid && frame_start) ? cfg_clamped : reff_q;

  assign cnt_base = sync ? '0 : cnt_q;
  assign acc_base = sync ? '0 : acc_q;
  assign sum      = acc_base + ACC_W'(in_data);
  assign cnt_inc  = cnt_base + CNT_W'(1);

  // The Nth sample closes the frame. Its own value is included in the sum.
  assign frame_done = in_valid && (cnt_inc == (CNT_W'(1) << reff_cur));

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    reff_d      = reff_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sum_d   = out_sum_q;
    overrun_d   = overrun_q;

    if (sync) begin
      acc_d = '0;
      cnt_d = '0;
    end

    if (in_valid) begin
      reff_d = reff_cur;
      if (frame_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end

    if (frame_done) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum;
      out_data_d  = DATA_W'(sum >> reff_cur);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // The set condition takes priority over the clear.
    if (frame_done && out_valid_q && !out_ready) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      reff_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sum_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      reff_q      <= reff_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sum_q   <= out_sum_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sum   = out_sum_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_decimator_acc.sv
// Testbench for decimator_acc: directed scenarios plus randomized traffic.
// The bench holds a frame-level reference model (a queue of frame samples)
// that is updated once per clock, and it compares every output on the
// falling edge.
module tb_decimator_acc;

  localparam int DATA_W    = 12;
  localparam int MAX_LOG2R = 9;
  localparam int ACC_W     = DATA_W + MAX_LOG2R;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [3:0]        cfg_log2r;
  logic              sync;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ACC_W-1:0]  out_sum;
  logic              overrun;
  logic              ovr_clr;

  decimator_acc #(.DATA_W(DATA_W), .MAX_LOG2R(MAX_LOG2R)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_log2r (cfg_log2r),
    .sync      (sync),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sum   (out_sum),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int unsigned frame_q[$];
  int unsigned m_reff  = 0;
  logic        m_valid = 1'b0;
  int unsigned m_data  = 0;
  int unsigned m_sum   = 0;
  logic        m_ovr   = 1'b0;
  logic [ACC_W-1:0] exp_q[$];  // frame sums the model has produced

  // Applies one clock edge to the model, using the inputs as they are now.
  task automatic model_update();
    bit          new_res;
    int unsigned s;
    new_res = 1'b0;
    s       = 0;
    if (rst) begin
      frame_q.delete();
      m_reff  = 0;
      m_valid = 1'b0;
      m_data  = 0;
      m_sum   = 0;
      m_ovr   = 1'b0;
      return;
    end
    if (sync) frame_q.delete();
    if (in_valid) begin
      if (frame_q.size() == 0)
        m_reff = (cfg_log2r > MAX_LOG2R) ? MAX_LOG2R : int'(cfg_log2r);
      frame_q.push_back(int'(in_data));
      if (frame_q.size() == (1 << m_reff)) begin
        foreach (frame_q[i]) s += frame_q[i];
        frame_q.delete();
        new_res = 1'b1;
      end
    end
    if (new_res && m_valid && !out_ready) m_ovr = 1'b1;
    else if (ovr_clr)                     m_ovr = 1'b0;
    if (new_res) begin
      m_valid = 1'b1;
      m_sum   = s;
      m_data  = s / (1 << m_reff);
      exp_q.push_back(ACC_W'(s));
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rst       = 1'b0;
    sync      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ovr_clr   = 1'b0;
  endtask

  // One clock: the edge updates the model, and the falling edge compares
  // every output against the model.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overrun",   32'(overrun),   32'(m_ovr));
    check("out_data",  32'(out_data),  m_data);
    check("out_sum",   32'(out_sum),   m_sum);
  endtask

  task automatic send(input int unsigned d);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    set_idle();
    cfg_log2r = 4'd0;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum",   32'(out_sum),   32'd0);

    // R=9 ramp, continuous input
    cfg_log2r = 4'd9;
    pulses = 0;
    for (int i = 0; i < 1024; i++) begin
      send(i % 4096);
      if (out_valid) pulses++;
      if (i == 511) begin
        check("ramp1_sum",  32'(out_sum),  32'd130816);
        check("ramp1_data", 32'(out_data), 32'd255);
      end
      if (i == 1023) begin
        check("ramp2_sum",  32'(out_sum),  32'd392960);
        check("ramp2_data", 32'(out_data), 32'd767);
      end
    end
    check("ramp_pulses", 32'(pulses), 32'd2);
    step();

    // R=9 full scale, no wrap
    for (int i = 0; i < 512; i++) send(4095);
    check("full_sum",  32'(out_sum),  32'd2096640);
    check("full_data", 32'(out_data), 32'd4095);
    step();

    // R=0 pass-through
    cfg_log2r = 4'd0;
    send(5);    check("r0_a", 32'(out_data), 32'd5);
    send(9);    check("r0_b", 32'(out_data), 32'd9);
    send(4095); check("r0_c", 32'(out_data), 32'd4095);
    check("r0_valid", 32'(out_valid), 32'd1);
    step();
    check("r0_drop", 32'(out_valid), 32'd0);

    // R=1 overwrite and overrun
    cfg_log2r = 4'd1;
    out_ready = 1'b0;
    send(10); send(20);
    check("ovr_first", 32'(out_data), 32'd15);
    send(30); send(40);
    step();
    check("ovr_second", 32'(out_data), 32'd35);
    check("ovr_flag",   32'(overrun),  32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ovr_consumed", 32'(out_valid), 32'd0);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);
    out_ready = 1'b1;

    // R=2 with sync discarding a partial frame
    cfg_log2r = 4'd2;
    for (int i = 0; i < 3; i++) send(100);
    sync = 1'b1; step(); sync = 1'b0;
    for (int i = 0; i < 4; i++) send(8);
    check("sync_sum",  32'(out_sum),  32'd32);
    check("sync_data", 32'(out_data), 32'd8);
    step();

    // cfg change mid-frame takes effect on the next frame only
    send(1); send(2);
    cfg_log2r = 4'd0;
    send(3);
    check("cfg_mid_noresult", 32'(out_valid), 32'd0);
    send(4);
    check("cfg_mid_sum", 32'(out_sum), 32'd10);
    send(77);
    check("cfg_next_r0", 32'(out_sum), 32'd77);
    step();

    // cfg 15 clamps to 9
    cfg_log2r = 4'd15;
    for (int i = 0; i < 512; i++) send(1);
    check("clamp_sum",  32'(out_sum),  32'd512);
    check("clamp_data", 32'(out_data), 32'd1);
    step();

    // Reset in the middle of a frame
    cfg_log2r = 4'd9;
    for (int i = 0; i < 200; i++) send($urandom_range(0, 4095));
    do_reset();
    check("midrst_sum",  32'(out_sum),  32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 512; i++) send(1);
    check("postrst_sum",  32'(out_sum),  32'd512);
    check("postrst_data", 32'(out_data), 32'd1);
    step();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 999) == 0);
      sync      = ($urandom_range(0, 63) == 0);
      ovr_clr   = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = DATA_W'($urandom_range(0, 4095));
      if ($urandom_range(0, 49) == 0)
        cfg_log2r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(0, 3));
      step();
    end
    set_idle();
    step();

    check("frames_seen", 32'(exp_q.size() > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/decimator_acc.md
DECIMATOR_ACC -- requirements
Module: decimator_acc

Interface
REQ-001 Parameter DATA_W, 12: input/output sample width, unsigned.
REQ-002 Parameter MAX_LOG2R, 9: largest supported log2 decimation ratio (ratio up to 512).
REQ-003 Derived ACC_W = DATA_W + MAX_LOG2R: accumulator and out_sum width, not overridable.
REQ-004 Port clk  in  1: single clock; all logic rising-edge.
REQ-005 Port rst  in  1: reset, synchronous, active-high.
REQ-006 Port cfg_log2r  in  4: requested log2 decimation ratio R.
REQ-007 Port sync  in  1: frame restart strobe.
REQ-008 Port in_valid  in  1: in_data qualifier; no backpressure on input.
REQ-009 Port in_data  in  DATA_W: unsigned input sample.
REQ-010 Port out_valid  out  1: out_data/out_sum hold an unconsumed result.
REQ-011 Port out_ready  in  1: consumer accepts result when out_valid && out_ready.
REQ-012 Port out_data  out  DATA_W: truncated frame average.
REQ-013 Port out_sum  out  ACC_W: full frame sum.
REQ-014 Port overrun  out  1: sticky flag, unconsumed result overwritten.
REQ-015 Port ovr_clr  in  1: clears overrun.

Function
REQ-016 Effective ratio N = 2^Reff, Reff = min(cfg_log2r, MAX_LOG2R); values above MAX_LOG2R clamp.
REQ-017 Reff is latched on the first accepted sample of each frame; cfg_log2r changes mid-frame take effect on the next frame.
REQ-018 Sample accepted on any cycle with in_valid=1; sample counter increments per accepted sample.
REQ-019 On the Nth accepted sample: result sum = sum of the N samples, including that sample; out_sum = sum, out_data = sum >> Reff (truncate, no rounding); out_valid = 1 the next cycle (latency 1 clock).
REQ-020 Accumulator and counter restart in the same cycle as the Nth sample; the following sample is sample 1 of the next frame; back-to-back input loses no samples.
REQ-021 Reff = 0: every accepted sample produces a result 1 cycle later with out_data = in_data.
REQ-022 Accumulator never wraps: ACC_W holds N*(2^DATA_W-1) for all legal N.
REQ-023 out_valid deasserts the cycle after handshake (out_valid && out_ready) unless a new result loads that cycle.
REQ-024 New result with out_valid=1 and out_ready=0: result overwrites output registers, out_valid stays 1, overrun set to 1 the next cycle.
REQ-025 New result while handshake occurs the same cycle: old result consumed, new result loaded, out_valid stays 1, overrun not set.
REQ-026 out_data/out_sum stable while out_valid=1 and no new result loads.
REQ-027 sync=1: partial accumulator and counter discarded; sync with in_valid=1 counts that sample as sample 1 of a fresh frame and latches Reff that cycle; sync does not affect out_valid, out_data, out_sum or overrun.
REQ-028 ovr_clr=1 clears overrun next cycle; simultaneous set condition wins (overrun stays 1).

Reset
REQ-029 rst=1 at a clock edge: accumulator=0, counter=0, latched Reff=0, out_valid=0, out_data=0, out_sum=0, overrun=0.
REQ-030 Reset mid-frame discards partial sum; first sample accepted after release starts a new frame with Reff latched then.
REQ-031 Reset dominates sync, ovr_clr and in_valid in the same cycle.

Verification
REQ-032 R=9, out_ready=1, in_valid=1 continuous ramp 0,1,2,... -> after sample 511: out_sum=130816, out_data=255; after sample 1023: out_sum=392960, out_data=767; one out_valid pulse per 512 samples.
REQ-033 R=9, 512 samples of 4095 -> out_sum=2096640, out_data=4095, no wrap.
REQ-034 R=0, in_data 5,9,4095 consecutive -> out_data 5,9,4095 one cycle later each, out_valid high 3 cycles.
REQ-035 R=1, out_ready=0, samples 10,20,30,40 -> first result 15; second result 35 overwrites, overrun=1; out_ready=1 consumes 35 once; ovr_clr pulse -> overrun=0.
REQ-036 R=2, 3 samples of 100, sync, then 4 samples of 8 -> single result out_sum=32, out_data=8; cfg_log2r changed to 0 mid-frame -> takes effect only after that frame; cfg_log2r=15 -> behaves as R=9.
REQ-037 rst asserted after 200 samples of a R=9 frame -> all outputs 0; next 512 samples of 1 after release -> out_sum=512, out_data=1.
